// File: rtl/mda_video_pkg.sv
// mda_video_pkg
//   Shared constants and types for the MDA dot-clock serializer.
//   - Default geometry (dots per character, underline scan row)
//   - MDA attribute byte encodings and bit positions
//   - Stage-A capture record for the CRTC outputs
//   - Helper that identifies the line-drawing character range
package mda_video_pkg;

  localparam int         DEF_DOTS_PER_CHAR = 9;
  localparam logic [4:0] DEF_UNDERLINE_ROW = 5'd12;

  // Attribute byte layout: [7] blink/bg-intensity, [6:4] background,
  // [3] foreground intensity, [2:0] foreground.
  localparam logic [7:0] ATTR_FG_BG_MASK = 8'h77;
  localparam logic [7:0] ATTR_BLANK      = 8'h00;
  localparam logic [7:0] ATTR_REVERSE    = 8'h70;
  localparam logic [7:0] ATTR_UL_MASK    = 8'h07;
  localparam logic [7:0] ATTR_UL_VALUE   = 8'h01;
  localparam int         ATTR_INTENS_BIT = 3;
  localparam int         ATTR_BLINK_BIT  = 7;

  // Phase numbers at which each pipeline step takes place.
  localparam logic [3:0] PH_CAPTURE  = 4'd0;
  localparam logic [3:0] PH_VRAM     = 4'd2;
  localparam logic [3:0] PH_FONT     = 4'd4;
  localparam logic [3:0] PH_CCLK_LOW = 4'd5;

  typedef struct packed {
    logic [4:0] ra;
    logic       de;
    logic       cursor;
    logic       hsync;
    logic       vsync;
  } stage_a_t;

  // Box/line-drawing characters extend into the ninth column.
  function automatic logic is_line_char(input logic [7:0] ch);
    return (ch >= 8'hC0) && (ch <= 8'hDF);
  endfunction

endpackage

// File: rtl/mda_attr_decode.sv
// mda_attr_decode
//   Combinational MDA attribute resolver for one character cell.
//   Ports:
//     char_code   character code (selects ninth-column behaviour)
//     attr        attribute byte
//     glyph       font row, MSB = leftmost pixel
//     ra          CRTC row address of this cell
//     de          display enable of this cell
//     cursor_vis  cursor present and in its visible blink phase
//     blink_phase slow blink phase (text blink)
//     blink_en    attr[7] acts as blink when set
//     pattern     9-bit pixel pattern, MSB shifted out first
//     intens      intensity for the whole cell
module mda_attr_decode
  import mda_video_pkg::*;
#(
  parameter int         DOTS_PER_CHAR = DEF_DOTS_PER_CHAR,
  parameter logic [4:0] UNDERLINE_ROW = DEF_UNDERLINE_ROW
) (
  input  logic [7:0] char_code,
  input  logic [7:0] attr,
  input  logic [7:0] glyph,
  input  logic [4:0] ra,
  input  logic       de,
  input  logic       cursor_vis,
  input  logic       blink_phase,
  input  logic       blink_en,
  output logic [8:0] pattern,
  output logic       intens
);

  logic       ninth;
  logic [8:0] glyph9;
  logic [7:0] attr_fg_bg;

  // In 8-dot mode the ninth bit is never shifted out, but keep it 0 anyway.
  assign ninth      = (DOTS_PER_CHAR == 9) && is_line_char(char_code) ? glyph[0] : 1'b0;
  assign glyph9     = {glyph, ninth};
  assign attr_fg_bg = attr & ATTR_FG_BG_MASK;

  always_comb begin
    pattern = glyph9;
    intens  = attr[ATTR_INTENS_BIT];
    if (!de) begin
      pattern = '0;
      intens  = 1'b0;
    end else if (cursor_vis) begin
      pattern = '1;
    end else if (attr_fg_bg == ATTR_BLANK) begin
      pattern = '0;
    end else if (attr_fg_bg == ATTR_REVERSE) begin
      // Reverse video ignores the intensity bit.
      pattern = ~glyph9;
      intens  = 1'b0;
    end else if (blink_en && attr[ATTR_BLINK_BIT] && blink_phase) begin
      pattern = '0;
    end else if (((attr & ATTR_UL_MASK) == ATTR_UL_VALUE) && (ra == UNDERLINE_ROW)) begin
      pattern = '1;
    end
  end

endmodule

// File: rtl/mda_video_serializer.sv
// mda_video_serializer
//   Dot-clock stage behind the MC6845: generates CCLK, captures the CRTC
//   outputs once per character, fetches char/attr and the glyph row, and
//   shifts out one pixel per CLK with intensity and one-character-delayed
//   syncs.
//   Ports:
//     CLK, RSTn                dot clock, async active-low reset
//     CCLK                     character clock to the CRTC
//     MA, RA, DE, CURSOR,
//     HSYNC, VSYNC             CRTC outputs, sampled at phase 0
//     BLINK_EN                 attr[7] selects blink when set
//     VRAM_ADDR, VRAM_DATA     VRAM word port, one-cycle read latency
//     FONT_ADDR, FONT_DATA     font ROM port, one-cycle read latency
//     VIDEO, INTENS,
//     HSYNC_O, VSYNC_O         pixel stream to the monitor interface
//
//   Pipeline per character (edges counted from the capture edge E):
//     E    capture CRTC into stage A, issue VRAM_ADDR, load shifter from C
//     E+2  take char/attr (stage B), issue FONT_ADDR
//     E+4  take glyph, resolve attribute into stage C
//     E+N  stage C reaches the shifter (N = DOTS_PER_CHAR)
module mda_video_serializer
  import mda_video_pkg::*;
#(
  parameter int         DOTS_PER_CHAR = DEF_DOTS_PER_CHAR,
  parameter logic [4:0] UNDERLINE_ROW = DEF_UNDERLINE_ROW
) (
  input  logic        CLK,
  input  logic        RSTn,
  output logic        CCLK,
  input  logic [13:0] MA,
  input  logic [4:0]  RA,
  input  logic        DE,
  input  logic        CURSOR,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        BLINK_EN,
  output logic [10:0] VRAM_ADDR,
  input  logic [15:0] VRAM_DATA,
  output logic [11:0] FONT_ADDR,
  input  logic [7:0]  FONT_DATA,
  output logic        VIDEO,
  output logic        INTENS,
  output logic        HSYNC_O,
  output logic        VSYNC_O
);

  localparam logic [3:0] PH_LAST = 4'(DOTS_PER_CHAR - 1);

  logic [3:0] phase;
  logic [3:0] phase_next;
  logic [4:0] frame_cnt;

  stage_a_t   stg_a;
  logic [7:0] char_b;
  logic [7:0] attr_b;
  logic [8:0] pat_c;
  logic       intens_c;
  logic       hsync_c;
  logic       vsync_c;
  logic [8:0] shifter;

  logic [8:0] dec_pattern;
  logic       dec_intens;

  // The VRAM window is 2K words; the upper MA bits are not decoded here.
  logic unused_ma_hi;
  assign unused_ma_hi = ^MA[13:11];

  assign phase_next = (phase == PH_LAST) ? PH_CAPTURE : phase + 4'd1;

  // Phase counter and CCLK. CCLK is registered from the next phase so it
  // is high exactly while phase is 0..4.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      phase <= PH_CAPTURE;
      CCLK  <= 1'b1;
    end else begin
      phase <= phase_next;
      CCLK  <= (phase_next < PH_CCLK_LOW);
    end
  end

  // Stage A capture, VRAM address and frame counter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stg_a     <= '0;
      VRAM_ADDR <= '0;
      frame_cnt <= '0;
    end else if (phase == PH_CAPTURE) begin
      stg_a.ra     <= RA;
      stg_a.de     <= DE;
      stg_a.cursor <= CURSOR;
      stg_a.hsync  <= HSYNC;
      stg_a.vsync  <= VSYNC;
      VRAM_ADDR    <= MA[10:0];
      // Counts even in blanked characters; DE plays no part here.
      if (VSYNC && !stg_a.vsync) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  // Stage B: character/attribute word and font address.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      char_b    <= '0;
      attr_b    <= '0;
      FONT_ADDR <= '0;
    end else if (phase == PH_VRAM) begin
      char_b    <= VRAM_DATA[7:0];
      attr_b    <= VRAM_DATA[15:8];
      FONT_ADDR <= {VRAM_DATA[7:0], stg_a.ra[3:0]};
    end
  end

  mda_attr_decode #(
    .DOTS_PER_CHAR (DOTS_PER_CHAR),
    .UNDERLINE_ROW (UNDERLINE_ROW)
  ) u_attr_decode (
    .char_code   (char_b),
    .attr        (attr_b),
    .glyph       (FONT_DATA),
    .ra          (stg_a.ra),
    .de          (stg_a.de),
    .cursor_vis  (stg_a.cursor & frame_cnt[3]),
    .blink_phase (frame_cnt[4]),
    .blink_en    (BLINK_EN),
    .pattern     (dec_pattern),
    .intens      (dec_intens)
  );

  // Stage C: resolved pattern plus the syncs that travel with it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pat_c    <= '0;
      intens_c <= 1'b0;
      hsync_c  <= 1'b0;
      vsync_c  <= 1'b0;
    end else if (phase == PH_FONT) begin
      pat_c    <= dec_pattern;
      intens_c <= dec_intens;
      hsync_c  <= stg_a.hsync;
      vsync_c  <= stg_a.vsync;
    end
  end

  // Output stage: shifter and per-character outputs all switch on the
  // capture edge, which keeps the syncs exactly one character behind.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shifter <= '0;
      INTENS  <= 1'b0;
      HSYNC_O <= 1'b0;
      VSYNC_O <= 1'b0;
    end else if (phase == PH_CAPTURE) begin
      shifter <= pat_c;
      INTENS  <= intens_c;
      HSYNC_O <= hsync_c;
      VSYNC_O <= vsync_c;
    end else begin
      shifter <= {shifter[7:0], 1'b0};
    end
  end

  assign VIDEO = shifter[8];

endmodule

// File: tb/tb_mda_video_serializer.sv
module tb_mda_video_serializer;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        CCLK;
  logic [13:0] MA = '0;
  logic [4:0]  RA = '0;
  logic        DE = 1'b0;
  logic        CURSOR = 1'b0;
  logic        HSYNC = 1'b0;
  logic        VSYNC = 1'b0;
  logic        BLINK_EN = 1'b0;
  logic [10:0] VRAM_ADDR;
  logic [15:0] VRAM_DATA = '0;
  logic [11:0] FONT_ADDR;
  logic [7:0]  FONT_DATA = '0;
  logic        VIDEO;
  logic        INTENS;
  logic        HSYNC_O;
  logic        VSYNC_O;

  mda_video_serializer #(
    .DOTS_PER_CHAR (9),
    .UNDERLINE_ROW (5'd12)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .CCLK      (CCLK),
    .MA        (MA),
    .RA        (RA),
    .DE        (DE),
    .CURSOR    (CURSOR),
    .HSYNC     (HSYNC),
    .VSYNC     (VSYNC),
    .BLINK_EN  (BLINK_EN),
    .VRAM_ADDR (VRAM_ADDR),
    .VRAM_DATA (VRAM_DATA),
    .FONT_ADDR (FONT_ADDR),
    .FONT_DATA (FONT_DATA),
    .VIDEO     (VIDEO),
    .INTENS    (INTENS),
    .HSYNC_O   (HSYNC_O),
    .VSYNC_O   (VSYNC_O)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read memories
  logic [15:0] vram [0:2047];
  logic [7:0]  font [0:4095];

  always @(posedge CLK) begin
    VRAM_DATA <= vram[VRAM_ADDR];
    FONT_DATA <= font[FONT_ADDR];
  end

  typedef struct packed {
    logic [8:0] pat;
    logic       intens;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic have_cur = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   ec = 0;
  int   mon_i;
  logic mon_en = 1'b0;
  logic exp_cclk;

  int   fc = 0;
  logic prev_vs = 1'b0;

  // Reference MDA attribute rules: returns {intens, pattern[8:0]}
  function automatic logic [9:0] ref_pixel(input logic [7:0] ch, input logic [7:0] attr,
                                           input logic [7:0] glyph, input logic [4:0] ra,
                                           input logic de, input logic cur_in,
                                           input logic blink_en, input logic [4:0] fcnt);
    logic [8:0] g;
    g = {glyph, ((ch >= 8'hC0) && (ch <= 8'hDF)) ? glyph[0] : 1'b0};
    if (!de) return {1'b0, 9'h000};
    if (cur_in && fcnt[3]) return {attr[3], 9'h1FF};
    if ((attr & 8'h77) == 8'h00) return {attr[3], 9'h000};
    if ((attr & 8'h77) == 8'h70) return {1'b0, ~g};
    if (blink_en && attr[7] && fcnt[4]) return {attr[3], 9'h000};
    if ((attr[2:0] == 3'b001) && (ra == 5'd12)) return {attr[3], 9'h1FF};
    return {attr[3], g};
  endfunction

  // Present one character to the DUT for one full character period and
  // push its expected pixel stream. Called right after a clock edge so that
  // the following edge is the capture edge.
  task automatic drive_char(input logic [13:0] ma, input logic [4:0] ra, input logic de,
                            input logic cur_in, input logic hs, input logic vs,
                            input logic [15:0] word, input logic [7:0] row);
    logic [9:0] r;
    exp_t e;
    vram[ma[10:0]] = word;
    font[{word[7:0], ra[3:0]}] = row;
    MA = ma;
    RA = ra;
    DE = de;
    CURSOR = cur_in;
    HSYNC = hs;
    VSYNC = vs;
    if (vs && !prev_vs) fc = (fc + 1) % 32;
    prev_vs = vs;
    r = ref_pixel(word[7:0], word[15:8], row, ra, de, cur_in, BLINK_EN, 5'(fc));
    e.pat = r[8:0];
    e.intens = r[9];
    e.hs = hs;
    e.vs = vs;
    sb.push_back(e);
    repeat (9) @(posedge CLK);
    #1;
  endtask

  // Output monitor: edge 0 is the first capture after reset release;
  // the character captured at edge 9k is emitted on edges 9k+9 .. 9k+17.
  always @(posedge CLK) begin
    if (mon_en) begin
      #1;
      mon_i = ec % 9;
      exp_cclk = (((ec + 1) % 9) <= 4);
      checks++;
      assert (CCLK === exp_cclk)
        else begin errors++; $error("FAIL cclk ec=%0d got %b want %b", ec, CCLK, exp_cclk); end
      if (ec >= 9) begin
        if (mon_i == 0) begin
          checks++;
          assert (sb.size() > 0)
            else begin errors++; $error("FAIL sb_empty ec=%0d got size 0 want >0", ec); end
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            have_cur = 1'b1;
          end else begin
            have_cur = 1'b0;
          end
        end
        if (have_cur) begin
          checks++;
          assert (VIDEO === cur.pat[8-mon_i])
            else begin errors++; $error("FAIL video ec=%0d dot=%0d got %b want %b (pattern %09b)", ec, mon_i, VIDEO, cur.pat[8-mon_i], cur.pat); end
          checks++;
          assert (INTENS === cur.intens)
            else begin errors++; $error("FAIL intens ec=%0d got %b want %b", ec, INTENS, cur.intens); end
          checks++;
          assert (HSYNC_O === cur.hs)
            else begin errors++; $error("FAIL hsync_o ec=%0d got %b want %b", ec, HSYNC_O, cur.hs); end
          checks++;
          assert (VSYNC_O === cur.vs)
            else begin errors++; $error("FAIL vsync_o ec=%0d got %b want %b", ec, VSYNC_O, cur.vs); end
        end
      end
      ec++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (VIDEO === 1'b0) else begin errors++; $error("FAIL %s video got %b want 0", tag, VIDEO); end
    checks++;
    assert (CCLK === 1'b1) else begin errors++; $error("FAIL %s cclk got %b want 1", tag, CCLK); end
    checks++;
    assert (INTENS === 1'b0) else begin errors++; $error("FAIL %s intens got %b want 0", tag, INTENS); end
    checks++;
    assert ({HSYNC_O, VSYNC_O} === 2'b00) else begin errors++; $error("FAIL %s syncs got %b want 00", tag, {HSYNC_O, VSYNC_O}); end
    checks++;
    assert (VRAM_ADDR === 11'd0) else begin errors++; $error("FAIL %s vram_addr got %h want 000", tag, VRAM_ADDR); end
    checks++;
    assert (FONT_ADDR === 12'd0) else begin errors++; $error("FAIL %s font_addr got %h want 000", tag, FONT_ADDR); end
  endtask

  // Release reset just after a clock edge; the next edge is the first capture.
  task automatic release_reset();
    @(posedge CLK);
    #1;
    sb.delete();
    fc = 0;
    prev_vs = 1'b0;
    ec = 0;
    RSTn = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) vram[i] = 16'h0700 ^ 16'(i * 37);
    for (int i = 0; i < 4096; i++) font[i] = 8'h5A ^ 8'(i);

    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Basic attribute and glyph cases
    drive_char(14'h0010, 5'd0,  1, 0, 0, 0, 16'h0741, 8'h18);  // normal 'A'
    drive_char(14'h0011, 5'd0,  1, 0, 0, 0, 16'h7041, 8'h18);  // reverse
    drive_char(14'h0012, 5'd0,  1, 0, 0, 0, 16'h0041, 8'h18);  // blank attr
    drive_char(14'h3813, 5'd0,  1, 0, 0, 0, 16'h07C4, 8'h01);  // line char, ninth copied
    drive_char(14'h0014, 5'd0,  1, 0, 0, 0, 16'h0741, 8'h01);  // ninth stays 0
    drive_char(14'h0015, 5'd12, 1, 0, 0, 0, 16'h0141, 8'h00);  // underline row
    drive_char(14'h0016, 5'd11, 1, 0, 0, 0, 16'h0141, 8'h00);  // not underline row
    drive_char(14'h0017, 5'd3,  1, 0, 0, 0, 16'h0F5A, 8'h81);  // intense
    drive_char(14'h0018, 5'd0,  0, 0, 0, 0, 16'h0F41, 8'hFF);  // display disabled
    drive_char(14'h0019, 5'd0,  1, 0, 1, 0, 16'h0741, 8'h3C);  // hsync asserted
    drive_char(14'h001A, 5'd0,  1, 0, 0, 0, 16'h0741, 8'h3C);  // hsync released
    drive_char(14'h001B, 5'd0,  1, 1, 0, 0, 16'h0741, 8'h3C);  // cursor, frame_cnt[3]=0
    drive_char(14'h001C, 5'd0,  1, 0, 0, 0, 16'h70C9, 8'h81);  // reverse line char

    // Blink: 24 VSYNC rising edges, some inside blanked characters
    BLINK_EN = 1'b1;
    for (int k = 0; k < 48; k++) begin
      drive_char(14'(14'h0100 + k), 5'd0, (k % 5) != 3, 0, 0, k[0], 16'h8741, 8'h5A);
    end
    drive_char(14'h0200, 5'd0, 1, 1, 0, 0, 16'h8F41, 8'h18);   // cursor visible
    drive_char(14'h0201, 5'd0, 1, 0, 0, 0, 16'h0741, 8'h18);   // non-blink attr
    drive_char(14'h0202, 5'd0, 1, 0, 0, 0, 16'h8741, 8'h18);   // blink attr suppressed
    BLINK_EN = 1'b0;
    drive_char(14'h0203, 5'd0, 1, 0, 0, 0, 16'h8741, 8'h18);   // blink disabled
    drive_char(14'h0204, 5'd0, 1, 0, 1, 1, 16'h0741, 8'hFF);

    // Reset in the middle of shifting a character out
    drive_char(14'h0300, 5'd0, 1, 0, 1, 0, 16'h0F41, 8'hFF);
    repeat (4) @(posedge CLK);
    #3;
    mon_en = 1'b0;
    RSTn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("midreset_hold");
    release_reset();

    drive_char(14'h0020, 5'd0, 1, 0, 0, 0, 16'h0741, 8'h18);
    drive_char(14'h0021, 5'd0, 1, 0, 0, 0, 16'h7041, 8'h18);
    drive_char(14'h0022, 5'd12, 1, 0, 0, 0, 16'h0941, 8'h24);
    drive_char(14'h0023, 5'd0, 0, 0, 0, 0, 16'h0000, 8'h00);
    drive_char(14'h0024, 5'd0, 0, 0, 0, 0, 16'h0000, 8'h00);
    mon_en = 1'b0;
    #20;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mda_video_serializer.md
# mda_video_serializer

Dot-clock stage directly downstream of the MC6845 CRTC in the MDA-style display path. It generates the character clock (CCLK) that drives the CRTC and captures the CRTC's MA, RA, DE, CURSOR, HSYNC and VSYNC once per character. It fetches the character/attribute word from VRAM and the glyph row from font ROM, applies MDA attribute rules, and shifts out one pixel per dot clock. Its outputs are video, intensity and syncs, realigned to the pixel stream and fed to the monitor interface.

## Interface
- DOTS_PER_CHAR, 9, dots per character cell; fixed at 9 for MDA, 8 also legal (no ninth column).
- UNDERLINE_ROW, 12, RA value on which underline attribute is drawn.
- CLK  in  1  dot clock; all logic on rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- CCLK  out  1  character clock to CRTC; high in phases 0..4, low in phases 5..DOTS_PER_CHAR-1.
- MA  in  14  CRTC memory address.
- RA  in  5  CRTC row address.
- DE, CURSOR, HSYNC, VSYNC  in  1 each  CRTC display enable, cursor, syncs.
- BLINK_EN  in  1  mode bit; 1 = attr[7] selects blink, 0 = attr[7] ignored.
- VRAM_ADDR  out  11  word address into VRAM.
- VRAM_DATA  in  16  {attr[15:8], char[7:0]}, synchronous read, valid one CLK after address.
- FONT_ADDR  out  12  {char, RA[3:0]}.
- FONT_DATA  in  8  glyph row, MSB = leftmost, synchronous read, valid one CLK after address.
- VIDEO, INTENS, HSYNC_O, VSYNC_O  out  1 each  pixel, intensity, delayed syncs.

## Operation
- Phase counter p cycles 0..DOTS_PER_CHAR-1 and wraps.
- Edge entering p=0: capture MA, RA, DE, CURSOR, HSYNC, VSYNC into stage A; VRAM_ADDR <= MA[10:0]. On the same edge, load the shifter from stage C and move stage-C syncs to HSYNC_O/VSYNC_O.
- Edge entering p=2: latch char/attr from VRAM_DATA; FONT_ADDR <= {char, RA[3:0]}.
- Edge entering p=4: latch FONT_DATA; compute 9-bit pattern and INTENS into stage C.
- Ninth column: if DOTS_PER_CHAR=9 and char in 0xC0..0xDF, it copies glyph bit 0; otherwise it is 0.
- Attribute decode, in priority order:
  - Stage-A DE=0 -> pattern 0, INTENS 0.
  - Cursor visible (CURSOR & frame_cnt[3]) -> pattern all ones, INTENS attr[3].
  - attr & 0x77 == 0x00 -> pattern 0.
  - attr & 0x77 == 0x70 -> pattern inverted, INTENS 0.
  - Blink (BLINK_EN & attr[7] & frame_cnt[4]) -> pattern 0.
  - attr[2:0]==001 and RA==UNDERLINE_ROW -> pattern all ones.
  - Otherwise glyph.
  - INTENS = attr[3] unless overridden above.
- frame_cnt: 5-bit counter, incremented on the CLK edge where captured VSYNC goes 0->1; wraps 31->0.
- Shifter outputs MSB first, one bit per CLK; VIDEO = shifter MSB.

## Timing
- Reset: p=0, CCLK=1, VIDEO=0, INTENS=0, HSYNC_O=0, VSYNC_O=0, VRAM_ADDR=0, FONT_ADDR=0, frame_cnt=0, shifter=0, stages cleared.
- Latency: a character captured at phase-0 edge E emits its first pixel on edge E+DOTS_PER_CHAR. HSYNC_O/VSYNC_O change on that same edge, so syncs have exactly one character of delay.
- CRTC updates on the CCLK falling edge (entry to p=5); inputs are stable by the next p=0 capture.
- Reset mid-character: everything returns to reset values immediately; the first capture is the first rising CLK edge after RSTn deasserts, which is phase 0.
- VSYNC rising in a blanked character: frame_cnt still increments.

## Structure
- Package mda_video_pkg: DOTS_PER_CHAR default, UNDERLINE_ROW, attribute constants ATTR_BLANK=0x00, ATTR_REVERSE=0x70, ATTR_UL_MASK, ATTR_INTENS_BIT, ATTR_BLINK_BIT.
- Sub-module mda_attr_decode (combinational): char, attr, glyph, RA, DE, cursor_vis, blink_phase, BLINK_EN -> 9-bit pattern and INTENS.

## Test plan
- Reset released, DE=1, VRAM 0x0741 ('A', normal), font row 0x18 -> VIDEO bits 000110000 starting at the capture edge + 9, INTENS=0, CCLK period 9 CLK.
- attr 0x70, font 0x18 -> 111001111, INTENS=0; attr 0x00 -> all zero.
- char 0xC4, font 0x01 -> 000000011 (ninth column copied); char 0x41, font 0x01 -> 000000010.
- attr 0x01, RA=12, font 0x00 -> 111111111; same at RA=11 -> all zero.
- BLINK_EN=1, attr 0x87: 16 VSYNC rising edges -> frame_cnt[4]=1, glyph suppressed; CURSOR=1 with frame_cnt[3]=1 -> 111111111.
- HSYNC asserted at a capture edge -> HSYNC_O rises exactly 9 CLK later; RSTn pulsed mid-shift -> VIDEO=0 and CCLK=1 during reset.
